// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin arbiter that shares the three read ports
// of an 8-entry register file among NREQ requesters.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req         per-requester read request (level, held until granted)
//   req_addr    register index of requester i at [3i+2:3i]
//   hold        pipeline stall, suppresses new grants
//   sel0..sel2  registered register selects for read ports 0..2
//   port_valid  bit p set when read port p carries a granted read
//   grant       one-cycle grant pulse per requester
//   grant_port  port assigned to requester i at [2i+1:2i], 2'b11 if none
//
// Optional feature macro: REGFILE_READ_MERGE_EN
//   When defined, a requester whose address matches a port already allocated
//   in the same arbitration shares that port instead of consuming a new one.
module regfile_read_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [3*NREQ-1:0]    req_addr,
   input  logic                 hold,
   output logic [2:0]           sel0,
   output logic [2:0]           sel1,
   output logic [2:0]           sel2,
   output logic [2:0]           port_valid,
   output logic [NREQ-1:0]      grant,
   output logic [2*NREQ-1:0]    grant_port
);

   localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned NPORT = 3;

   logic [IW-1:0]      rr_ptr;
   logic [2:0]         sel_q [NPORT];
   logic [2:0]         pv_q;
   logic [NREQ-1:0]    grant_q;
   logic [2*NREQ-1:0]  gport_q;

   logic [2:0]         addr_a [NREQ];
   logic [2:0]         n_sel [NPORT];
   logic [2:0]         n_pv;
   logic [NREQ-1:0]    n_grant;
   logic [1:0]         n_gp [NREQ];
   logic [2*NREQ-1:0]  n_gport;
   logic [IW-1:0]      n_rr;
   logic [IW-1:0]      idx;
   logic [IW-1:0]      last;
   logic [1:0]         nalloc;
   logic [1:0]         port;
   logic               hit;
   logic               any;

   // Unpack the flat address bus into one entry per requester
   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         addr_a[i] = req_addr[3*i +: 3];
      end
   end

   // Round-robin scan from rr_ptr, filling ports 0..2 in scan order
   always_comb begin
      n_sel   = sel_q;
      n_pv    = 3'b000;
      n_grant = '0;
      n_rr    = rr_ptr;
      idx     = '0;
      last    = '0;
      nalloc  = 2'd0;
      port    = 2'd0;
      hit     = 1'b0;
      any     = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
         n_gp[i] = 2'b11;
      end

      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IW'((32'(rr_ptr) + k) % NREQ);
         hit = 1'b0;
         port = 2'd0;
         // Masking last cycle's winners stops a held request being granted twice
         if (req[idx] && !grant_q[idx]) begin
`ifdef REGFILE_READ_MERGE_EN
            for (int p = 0; p < int'(NPORT); p++) begin
               if (!hit && (2'(p) < nalloc) && (n_sel[p] == addr_a[idx])) begin
                  hit  = 1'b1;
                  port = 2'(p);
               end
            end
`endif
            if (!hit && (nalloc < 2'd3)) begin
               hit  = 1'b1;
               port = nalloc;
               for (int p = 0; p < int'(NPORT); p++) begin
                  if (2'(p) == nalloc) begin
                     n_sel[p] = addr_a[idx];
                     n_pv[p]  = 1'b1;
                  end
               end
               nalloc = nalloc + 2'd1;
            end
            if (hit) begin
               n_grant[idx] = 1'b1;
               n_gp[idx]    = port;
               last         = idx;
               any          = 1'b1;
            end
         end
      end

      if (any) begin
         n_rr = (last == IW'(NREQ - 1)) ? '0 : last + IW'(1);
      end

      for (int i = 0; i < int'(NREQ); i++) begin
         n_gport[2*i +: 2] = n_gp[i];
      end
   end

   // Output and pointer registers; unallocated port selects keep their value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int p = 0; p < int'(NPORT); p++) begin
            sel_q[p] <= 3'b000;
         end
         pv_q    <= 3'b000;
         grant_q <= '0;
         gport_q <= '1;
         rr_ptr  <= '0;
      end else if (hold) begin
         pv_q    <= 3'b000;
         grant_q <= '0;
         gport_q <= '1;
      end else begin
         sel_q   <= n_sel;
         pv_q    <= n_pv;
         grant_q <= n_grant;
         gport_q <= n_gport;
         rr_ptr  <= n_rr;
      end
   end

   assign sel0       = sel_q[0];
   assign sel1       = sel_q[1];
   assign sel2       = sel_q[2];
   assign port_valid = pv_q;
   assign grant      = grant_q;
   assign grant_port = gport_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed and randomized checks of
// regfile_read_arbiter against a queue-based reference model.
module tb_regfile_read_arbiter;

   localparam int unsigned NREQ = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               hold = 1'b0;
   logic [NREQ-1:0]    req = '0;
   logic [2:0]         addr [NREQ];
   logic [3*NREQ-1:0]  req_addr;
   logic [2:0]         sel0, sel1, sel2;
   logic [2:0]         port_valid;
   logic [NREQ-1:0]    grant;
   logic [2*NREQ-1:0]  grant_port;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [NREQ-1:0]    m_grant = '0;
   logic [1:0]         m_gp [NREQ];
   logic [2:0]         m_sel [3];
   logic [2:0]         m_pv = 3'b000;
   int                 m_rr = 0;

   regfile_read_arbiter #(.NREQ(NREQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_addr   (req_addr),
      .hold       (hold),
      .sel0       (sel0),
      .sel1       (sel1),
      .sel2       (sel2),
      .port_valid (port_valid),
      .grant      (grant),
      .grant_port (grant_port)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < int'(NREQ); i++) begin
         req_addr[3*i +: 3] = addr[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2*NREQ-1:0] pack_gp();
      logic [2*NREQ-1:0] v;
      for (int i = 0; i < int'(NREQ); i++) begin
         v[2*i +: 2] = m_gp[i];
      end
      return v;
   endfunction

   // Expected outputs after an edge, from the arbitration rules
   task automatic model_edge();
      int          order[$];
      logic [2:0]  alloc[$];
      logic [NREQ-1:0] g;
      int          lastg;
      int          p;
      int          i;
      if (!rst_n) begin
         m_grant = '0;
         m_pv    = 3'b000;
         m_rr    = 0;
         for (int j = 0; j < 3; j++) m_sel[j] = 3'b000;
         for (int j = 0; j < int'(NREQ); j++) m_gp[j] = 2'b11;
      end else if (hold) begin
         m_grant = '0;
         m_pv    = 3'b000;
         for (int j = 0; j < int'(NREQ); j++) m_gp[j] = 2'b11;
      end else begin
         g = '0;
         lastg = -1;
         m_pv = 3'b000;
         for (int j = 0; j < int'(NREQ); j++) m_gp[j] = 2'b11;
         for (int k = 0; k < int'(NREQ); k++) begin
            i = (m_rr + k) % int'(NREQ);
            if (req[i] && !m_grant[i]) order.push_back(i);
         end
         foreach (order[j]) begin
            i = order[j];
            p = -1;
`ifdef REGFILE_READ_MERGE_EN
            foreach (alloc[q]) if (p < 0 && alloc[q] == addr[i]) p = q;
`endif
            if (p < 0 && alloc.size() < 3) begin
               alloc.push_back(addr[i]);
               p = alloc.size() - 1;
               m_sel[p] = addr[i];
               m_pv[p]  = 1'b1;
            end
            if (p >= 0) begin
               g[i]    = 1'b1;
               m_gp[i] = 2'(p);
               lastg   = i;
            end
         end
         if (lastg >= 0) m_rr = (lastg + 1) % int'(NREQ);
         m_grant = g;
      end
   endtask

   task automatic compare_all();
      check("grant",      32'(grant),      32'(m_grant));
      check("port_valid", 32'(port_valid), 32'(m_pv));
      check("sel0",       32'(sel0),       32'(m_sel[0]));
      check("sel1",       32'(sel1),       32'(m_sel[1]));
      check("sel2",       32'(sel2),       32'(m_sel[2]));
      check("grant_port", 32'(grant_port), 32'(pack_gp()));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < int'(NREQ); i++) begin
         addr[i] = 3'd0;
         m_gp[i] = 2'b11;
      end
      for (int j = 0; j < 3; j++) m_sel[j] = 3'd0;

      // Reset with all requests asserted
      rst_n = 1'b0;
      req   = '1;
      step();
      check("rst1_gport", 32'(grant_port), 32'hFF);
      step();
      check("rst2_grant", 32'(grant), 32'h0);
      check("rst2_pv",    32'(port_valid), 32'h0);

      // Round-robin rotation
      addr[0] = 3'd1; addr[1] = 3'd2; addr[2] = 3'd3; addr[3] = 3'd4;
      rst_n = 1'b1;
      step();
      check("rr1_grant", 32'(grant), 32'b0111);
      check("rr1_sel0",  32'(sel0),  32'd1);
      check("rr1_sel2",  32'(sel2),  32'd3);
      req = ~m_grant;
      step();
      check("rr2_grant", 32'(grant), 32'b1000);
      check("rr2_sel0",  32'(sel0),  32'd4);
      check("rr2_pv",    32'(port_valid), 32'b001);
      req = ~m_grant;
      step();
      check("rr3_grant", 32'(grant), 32'b0111);

      // Single requester, with a held request masked for one cycle
      req = '0;
      do_reset();
      req = 4'b0100;
      addr[2] = 3'd7;
      step();
      check("single_grant", 32'(grant),      32'b0100);
      check("single_gport", 32'(grant_port), 32'hCF);
      check("single_sel0",  32'(sel0),       32'd7);
      check("single_pv",    32'(port_valid), 32'b001);
      step();
      check("single_mask",  32'(grant),      32'h0);
      step();
      check("single_again", 32'(grant),      32'b0100);

      // Hold suppresses grants without losing them
      req = '0;
      do_reset();
      req = 4'b0011;
      addr[0] = 3'd6; addr[1] = 3'd2;
      hold = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         check("hold_grant", 32'(grant), 32'h0);
         check("hold_sel0",  32'(sel0),  32'h0);
      end
      hold = 1'b0;
      step();
      check("hold_rel_grant", 32'(grant),      32'b0011);
      check("hold_rel_pv",    32'(port_valid), 32'b011);
      check("hold_rel_sel1",  32'(sel1),       32'd2);

      // Duplicate addresses
      req = '0;
      do_reset();
      req = '1;
      for (int i = 0; i < int'(NREQ); i++) addr[i] = 3'd5;
      step();
`ifdef REGFILE_READ_MERGE_EN
      check("dup_grant", 32'(grant),      32'b1111);
      check("dup_gport", 32'(grant_port), 32'h00);
      check("dup_pv",    32'(port_valid), 32'b001);
      check("dup_sel0",  32'(sel0),       32'd5);
`else
      check("dup_grant", 32'(grant),      32'b0111);
      check("dup_sel1",  32'(sel1),       32'd5);
      check("dup_pv",    32'(port_valid), 32'b111);
      req = ~m_grant;
      step();
      check("dup_next",  32'(grant),      32'b1000);
`endif

      // Randomized handshaking requesters with random hold and rare reset
      req = '0;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (req[i] && m_grant[i]) begin
               if ($urandom_range(3) != 0) req[i] = 1'b0;
               else addr[i] = 3'($urandom);
            end else if (!req[i] && $urandom_range(2) == 0) begin
               req[i]  = 1'b1;
               addr[i] = 3'($urandom_range(7));
            end
         end
         hold  = ($urandom_range(9) == 0);
         rst_n = ($urandom_range(199) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares the three 16-bit register-file read ports among NREQ requesters (decoder, ALU operand fetch, store unit, debug).
- Ports are sel0/sel1/sel2 into the 8-register, 3-read-port selector.
- Each cycle it arbitrates pending read requests round-robin, assigns up to three winners to ports 0..2, and drives the 3-bit port selects plus per-requester grant and port index.
- It sits between the requesters and the register-file read selector.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req  input  NREQ  per-requester read request, level.
- req_addr  input  3*NREQ  register index for requester i, at bits [3i+2:3i].
- hold  input  1  pipeline stall; suppresses new grants.
- sel0  output  3  register select, read port 0.
- sel1  output  3  register select, read port 1.
- sel2  output  3  register select, read port 2.
- port_valid  output  3  bit p high means read port p carries a granted read this cycle.
- grant  output  NREQ  one-cycle grant pulse per requester.
- grant_port  output  2*NREQ  port (0..2) assigned to requester i, at bits [2i+1:2i]; 2'b11 when not granted.

Behaviour:
- Reset: sel0/sel1/sel2 = 3'b000, port_valid = 3'b000, grant = 0, grant_port = all 2'b11, round-robin pointer rr_ptr = 0. Reset overrides hold and req; mid-operation reset drops all pending grants at that edge.
- All outputs are registered. Latency is 1 cycle: req/req_addr sampled at edge N appear as grant/sel at cycle N+1.
- Eligibility at an edge: req[i]=1 AND grant[i]=0. A requester granted in the current cycle is masked, so one held request is never granted on two consecutive edges.
- Handshake: the requester holds req and req_addr stable until it sees grant[i]=1. It deasserts req during the grant cycle; req still high at the following edge counts as a new request.
- Scan order: rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
- Port allocation: the first eligible requester takes port 0, the second port 1, the third port 2. Remaining eligible requesters wait.
- For each allocated port p: sel_p = that requester's req_addr, and port_valid[p]=1.
- For each unallocated port: port_valid[p]=0 and sel_p holds its previous value, so the datapath mux does not toggle.
- rr_ptr update: (index of last granted requester + 1) mod NREQ. Unchanged if nothing is granted.
- Fairness: with NREQ<=3 every eligible requester is granted each arbitration. With NREQ>3, a continuously requesting requester waits at most ceil(NREQ/3) arbitrations.
- hold=1 at an edge: next cycle has grant=0, port_valid=0, grant_port all 2'b11, sels held, rr_ptr unchanged. Pending requests stay pending; no grant is lost or duplicated.
- Duplicate addresses: without the optional feature, two requesters reading the same register each consume a separate port.
- req_addr of a non-requesting lane is ignored.
- grant_port for a granted lane is 2'b00/01/10. It is never 2'b11 while grant[i]=1.

Optional Feature:
- Macro: REGFILE_READ_MERGE_EN.
- Defined: during the scan, an eligible requester whose req_addr equals the address already allocated to a port in this arbitration is granted onto that port (same grant_port) without consuming a new port.
  - More than three grants per cycle are then possible, up to NREQ.
  - rr_ptr still follows the last granted index in scan order.
  - A requester is skipped only when all three ports are allocated and its address matches none of them.
- Not defined: no address comparison; strictly at most three grants per cycle, one per port.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> the cycle after each reset edge shows grant=0, port_valid=000, sels=000, grant_port=8'hFF. After release, the first grants go to requesters 0,1,2 on ports 0,1,2.
- Round-robin rotation, NREQ=4, req held at 4'b1111 with 1-cycle deassert after each grant:
  - Addrs r0=1, r1=2, r2=3, r3=4.
  - Arbitration 1: grants 0,1,2 with sel0=1, sel1=2, sel2=3.
  - Arbitration 2: grant 3 on port 0 (sel0=4) first; the subsequent scan starts at requester 0.
- Single requester: only req[2]=1 with addr=7 -> next cycle grant=4'b0100, grant_port[5:4]=00, sel0=7, port_valid=001. Requester holds req one more edge -> grant=0 that cycle (mask), granted again one cycle later.
- Hold: req=4'b0011 with hold=1 for 3 edges -> no grants, sels unchanged, rr_ptr unchanged. Release hold -> requesters 0 and 1 granted on ports 0 and 1 next cycle.
- Duplicate address, feature off: req=4'b1111, all addrs=5 -> three grants, sel0=sel1=sel2=5, requester 3 granted in the following arbitration.
- Duplicate address, feature on: same stimulus -> grant=4'b1111 in one cycle, all grant_port=00, port_valid=001, sel0=5.
